// File: rtl/addsub_pkg.sv
// Shared types for the sequential add/subtract/compare unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    typedef struct packed {
        logic neg;
        logic zr;
        logic cry;
        logic of;
    } flags_t;

    function automatic logic is_sub_op(input op_t o);
        return (o == OP_SUB) || (o == OP_CMP);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// K-bit ripple adder slice; sub=1 inverts b so that a-b = a + ~b + 1 with cin=1.
module addsub_slice #(
    parameter int K = 2
) (
    input  logic [K-1:0] a_s,
    input  logic [K-1:0] b_s,
    input  logic         cin,
    input  logic         sub,
    output logic [K-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [K:0]   c;
    logic [K-1:0] bx;

    always_comb begin
        c    = '0;
        s    = '0;
        bx   = b_s ^ {K{sub}};
        c[0] = cin;
        for (int unsigned i = 0; i < K; i++) begin
            s[i]   = a_s[i] ^ bx[i] ^ c[i];
            c[i+1] = (a_s[i] & bx[i]) | (c[i] & (a_s[i] ^ bx[i]));
        end
        cout = c[K];
        cmsb = c[K-1];
    end

endmodule

// File: rtl/addsub_seq_nbits.sv
// Multi-cycle add/sub/compare: one K-bit slice per cycle, LSB first, registered result and N/Z/C/V flags.
module addsub_seq_nbits
    import addsub_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         neg_flag,
    output logic         zr_flag,
    output logic         cry_flag,
    output logic         of_flag
);

    localparam int BW = $clog2(N + 1);

    state_t         state, state_nx;
    op_t            op_r;
    logic [N-1:0]   a_r, b_r, acc;
    logic [BW-1:0]  base;
    logic           carry, c_msb;
    logic           sub_r, last;
    logic [K-1:0]   s;
    logic           cout, cmsb;
    flags_t         fl, fl_r;

    // Internally the chain carries a true carry; SUB starts with carry=1 (borrow_in=0).
    assign sub_r = is_sub_op(op_r);
    assign last  = (base == BW'(N - K));

    addsub_slice #(.K(K)) u_slice (
        .a_s  (a_r[base +: K]),
        .b_s  (b_r[base +: K]),
        .cin  (carry),
        .sub  (sub_r),
        .s    (s),
        .cout (cout),
        .cmsb (cmsb)
    );

    always_comb begin
        fl.neg = acc[N-1];
        fl.zr  = (acc == '0);
        fl.cry = sub_r ? ~carry : carry;
        fl.of  = carry ^ c_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= OP_ADD;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            base   <= '0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            result <= '0;
            fl_r   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op_t'(op);
                        base  <= '0;
                        carry <= is_sub_op(op_t'(op));
                    end
                end
                S_RUN: begin
                    acc[base +: K] <= s;
                    carry          <= cout;
                    c_msb          <= cmsb;
                    base           <= base + BW'(K);
                end
                S_FIN: begin
                    done <= 1'b1;
                    fl_r <= fl;
                    if (op_r != OP_CMP) result <= acc;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign neg_flag = fl_r.neg;
    assign zr_flag  = fl_r.zr;
    assign cry_flag = fl_r.cry;
    assign of_flag  = fl_r.of;

endmodule
